// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/forward controller for a 5-stage pipeline.
// It detects load-use hazards and multi-cycle data-memory accesses, drives
// the enable/bubble controls of the PC and the pipeline registers, and picks
// ALU operand forwarding sources from EX/MEM and MEM/WB.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   id_rs/id_rt/id_use_*      ID-stage source registers and their use flags
//   ex_rn/ex_wreg/ex_m2reg    EX-stage destination, write and load flags
//   mem_rn/mem_wreg/mem_m2reg MEM-stage destination, write and load flags
//   mem_req, dmem_ready       data-memory access request / completion
//   wb_rn/wb_wreg             WB-stage destination and write flag
//   pc_en ... mem_wb_bubble   combinational (Mealy) stall controls
//   fwd_a, fwd_b              combinational forwarding selects
//   err_timeout               sticky dmem timeout flag (registered)
//   stall_cnt                 saturating count of pc_en = 0 cycles (registered)
module pipe_hazard_ctrl #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    id_rs,
  input  logic [4:0]    id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic [4:0]    ex_rn,
  input  logic          ex_wreg,
  input  logic          ex_m2reg,
  input  logic [4:0]    mem_rn,
  input  logic          mem_wreg,
  input  logic          mem_m2reg,
  input  logic          mem_req,
  input  logic          dmem_ready,
  input  logic [4:0]    wb_rn,
  input  logic          wb_wreg,
  output logic          pc_en,
  output logic          if_id_en,
  output logic          id_ex_en,
  output logic          id_ex_bubble,
  output logic          ex_mem_en,
  output logic          mem_wb_bubble,
  output logic [1:0]    fwd_a,
  output logic [1:0]    fwd_b,
  output logic          err_timeout,
  output logic [CW-1:0] stall_cnt
);

  localparam int unsigned WW = 8;
  localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT - 1);

  typedef enum logic {ST_RUN = 1'b0, ST_WAIT = 1'b1} state_t;

  state_t        state;
  logic [WW-1:0] wait_cnt;
  logic          luh;
  logic          memstall;
  logic          timeout_hit;

  // Forwarding source for one operand; a load in MEM never forwards.
  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (mem_wreg && !mem_m2reg && (mem_rn != 5'd0) && (mem_rn == src))
      return 2'b01;
    else if (wb_wreg && (wb_rn != 5'd0) && (wb_rn == src))
      return 2'b10;
    else
      return 2'b00;
  endfunction

  // Hazard detection and Mealy stall outputs.
  always_comb begin
    luh = ex_m2reg && ex_wreg && (ex_rn != 5'd0) &&
          ((id_use_rs && (ex_rn == id_rs)) || (id_use_rt && (ex_rn == id_rt)));
    timeout_hit = (state == ST_WAIT) && !dmem_ready && (wait_cnt == WAIT_LAST);
    memstall = ((state == ST_RUN) && mem_req && !dmem_ready) ||
               ((state == ST_WAIT) && !dmem_ready && (wait_cnt != WAIT_LAST));

    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_en     = 1'b1;
    mem_wb_bubble = 1'b0;
    fwd_a         = 2'b00;
    fwd_b         = 2'b00;

    if (!rst) begin
      fwd_a = fwd_sel(id_rs);
      fwd_b = fwd_sel(id_rt);
      if (memstall) begin
        // Freeze everything up to MEM, drain a NOP into WB.
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_ex_en      = 1'b0;
        ex_mem_en     = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (luh) begin
        // Hold IF/ID one cycle and insert a bubble behind the load.
        pc_en        = 1'b0;
        if_id_en     = 1'b0;
        id_ex_bubble = 1'b1;
      end
    end
  end

  // Memory-wait FSM, watchdog, sticky error and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RUN;
      wait_cnt    <= '0;
      err_timeout <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      if (!pc_en && (stall_cnt != {CW{1'b1}}))
        stall_cnt <= stall_cnt + CW'(1);

      case (state)
        ST_RUN: begin
          if (mem_req && !dmem_ready) begin
            state    <= ST_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_WAIT: begin
          if (dmem_ready) begin
            state <= ST_RUN;
          end else if (timeout_hit) begin
            state       <= ST_RUN;
            err_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/forward controller for the 5-stage pipelined CPU (IF, ID, EX, MEM, WB). It detects load-use hazards and multi-cycle data-memory accesses, and drives the enable and bubble inputs of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also produces ALU operand forwarding selects from the EX/MEM and MEM/WB stages. It holds a small FSM for memory wait sequencing, a timeout watchdog and a stall-cycle performance counter.

Parameters:
TIMEOUT, 16, maximum WAIT-state cycles before dmem access is abandoned; legal range 2..255.
CW, 16, width of the stall performance counter.

Ports:
clk  in  1  pipeline clock, rising edge.
rst  in  1  synchronous reset, active-high.
id_rs  in  5  ID-stage source register 1.
id_rt  in  5  ID-stage source register 2.
id_use_rs  in  1  ID instruction reads rs.
id_use_rt  in  1  ID instruction reads rt.
ex_rn  in  5  EX-stage destination register.
ex_wreg  in  1  EX instruction writes the register file.
ex_m2reg  in  1  EX instruction is a load.
mem_rn  in  5  MEM-stage destination register.
mem_wreg  in  1  MEM instruction writes the register file.
mem_m2reg  in  1  MEM instruction is a load.
mem_req  in  1  MEM instruction accesses data memory (load or store).
dmem_ready  in  1  data memory completes the access this cycle.
wb_rn  in  5  WB-stage destination register.
wb_wreg  in  1  WB instruction writes the register file.
pc_en  out  1  PC write enable.
if_id_en  out  1  IF/ID write enable.
id_ex_en  out  1  ID/EX write enable.
id_ex_bubble  out  1  load zeros (NOP) into ID/EX.
ex_mem_en  out  1  EX/MEM write enable.
mem_wb_bubble  out  1  load zeros (NOP) into MEM/WB.
fwd_a  out  2  operand A source: 00 = register file, 01 = EX/MEM ALU result, 10 = MEM/WB writeback value.
fwd_b  out  2  operand B source, same encoding as fwd_a.
err_timeout  out  1  sticky flag: a dmem access timed out.
stall_cnt  out  CW  count of cycles with pc_en = 0, saturating.

Behaviour:
- clk is the only clock. rst is sampled only on the rising edge of clk.
- Reset: state = RUN, wait_cnt = 0, err_timeout = 0, stall_cnt = 0.
- While rst = 1, combinational outputs are forced to non-stall values: all enables = 1, both bubbles = 0, fwd_a = fwd_b = 00.
- FSM states are RUN and WAIT. All stall outputs are Mealy, so a stall applies in the same cycle the condition appears.
- Load-use hazard, luh = ex_m2reg & ex_wreg & (ex_rn != 0) & ((id_use_rs & ex_rn == id_rs) | (id_use_rt & ex_rn == id_rt)).
- memstall = (state == RUN & mem_req & !dmem_ready) | (state == WAIT & !dmem_ready & wait_cnt != TIMEOUT-1).
- When memstall = 1 (highest priority):
  - pc_en = if_id_en = id_ex_en = ex_mem_en = 0.
  - mem_wb_bubble = 1, id_ex_bubble = 0.
  - luh is ignored this cycle.
- Else when luh = 1:
  - pc_en = if_id_en = 0.
  - id_ex_en = 1, id_ex_bubble = 1.
  - ex_mem_en = 1, mem_wb_bubble = 0.
  - The stall lasts exactly 1 cycle, because the load then advances out of EX.
- Else: all enables = 1, both bubbles = 0.
- Transitions:
  - RUN -> WAIT when mem_req & !dmem_ready; wait_cnt is cleared to 0.
  - WAIT -> RUN when dmem_ready.
  - WAIT -> RUN on timeout (!dmem_ready & wait_cnt == TIMEOUT-1): err_timeout is set to 1 and the pipeline is released in that cycle.
  - WAIT stays WAIT otherwise, with wait_cnt incrementing by 1.
  - dmem_ready in RUN is a single-cycle access: no stall.
- err_timeout is cleared only by rst.
- stall_cnt increments on every clock edge where pc_en = 0 and rst = 0, and holds at 2^CW-1.
- Forwarding is combinational and independent of stalls; fwd_b uses id_rt with the same rules as fwd_a below.
  - fwd_a = 01 if mem_wreg & !mem_m2reg & mem_rn != 0 & mem_rn == id_rs.
  - fwd_a = 10 elif wb_wreg & wb_rn != 0 & wb_rn == id_rs.
  - fwd_a = 00 otherwise.
  - MEM has priority over WB.
  - A load in MEM never forwards (it is covered by luh).
- Reset asserted mid-WAIT returns the FSM to RUN on the next edge, regardless of dmem_ready.

Test Plan:
- Reset: rst = 1 for 2 cycles with mem_req = 1, dmem_ready = 0 -> pc_en = 1, fwd = 00, err_timeout = 0, stall_cnt = 0; state RUN after release.
- Load-use: ex_m2reg = 1, ex_wreg = 1, ex_rn = 5, id_rs = 5, id_use_rs = 1 for 1 cycle -> exactly 1 cycle of pc_en = 0, if_id_en = 0, id_ex_bubble = 1; stall_cnt = 1. Repeat with ex_rn = 0 -> no stall.
- Memory wait: mem_req = 1, dmem_ready low for 3 cycles then high -> 3 cycles of all enables 0 and mem_wb_bubble = 1; released on the ready cycle; stall_cnt = 3; luh asserted meanwhile produces no id_ex_bubble.
- Timeout (TIMEOUT = 4): mem_req = 1, dmem_ready = 0 held -> stall for 4 cycles (1 RUN + 3 WAIT), release in the 5th cycle, err_timeout = 1 sticky until rst.
- Forwarding: mem_wreg = 1, mem_rn = 3; wb_wreg = 1, wb_rn = 3; id_rs = 3, id_rt = 3 -> fwd_a = fwd_b = 01. With mem_m2reg = 1 -> 10. With rn = 0 -> 00.
- Saturation (CW = 4): hold memstall for 20 cycles -> stall_cnt stops at 15.
